// File: rtl/nic_flit_injector.sv
// nic_flit_injector: injection endpoint for one router input port.
// Stages per-VC flits in small FIFOs, grants one credit-eligible VC per cycle
// in round-robin order and registers the popped flit onto channel_out.
// Credits return on flow_ctrl_in; a return to a VC whose counter is already
// full sets the sticky error flag.
// Optional feature macro: NIC_INJ_PROTO_CHECK_EN (per-VC head/tail packet
// framing check on granted flits; framing violations also set error).
module nic_flit_injector #(
  parameter int NUM_VCS         = 2,
  parameter int VC_IDX_WIDTH    = 1,
  parameter int FLIT_DATA_WIDTH = 64,
  parameter int CREDITS_PER_VC  = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_VCS-1:0]                 src_valid,
  output logic [NUM_VCS-1:0]                 src_ready,
  input  logic [NUM_VCS-1:0]                 src_head,
  input  logic [NUM_VCS-1:0]                 src_tail,
  input  logic [NUM_VCS*FLIT_DATA_WIDTH-1:0] src_data,
  output logic [FLIT_DATA_WIDTH+3:0]         channel_out,
  input  logic [VC_IDX_WIDTH:0]              flow_ctrl_in,
  output logic                               error,
  output logic                               idle
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CRED_W = $clog2(CREDITS_PER_VC + 1);
  localparam int ENT_W  = FLIT_DATA_WIDTH + 2;  // {tail, head, data}

  logic [NUM_VCS-1:0]            fifo_full;
  logic [NUM_VCS-1:0]            fifo_empty;
  logic [NUM_VCS-1:0]            push;
  logic [NUM_VCS-1:0]            pop;
  logic [NUM_VCS-1:0]            ret;
  logic [NUM_VCS-1:0]            eligible;
  logic [NUM_VCS-1:0]            credit_full;
  logic [NUM_VCS-1:0]            ovf;
  logic [NUM_VCS-1:0]            proto_bad;
  logic [NUM_VCS-1:0][ENT_W-1:0] head_ent;

  logic                          gnt_vld;
  logic [VC_IDX_WIDTH-1:0]       gnt_vc;
  logic [VC_IDX_WIDTH-1:0]       rr_ptr;
  logic [ENT_W-1:0]              gnt_ent;
  logic [FLIT_DATA_WIDTH+3:0]    chan_p1;
  logic                          error_q;

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    logic [PTR_W:0]      wr_ptr;
    logic [PTR_W:0]      rd_ptr;
    logic [CRED_W-1:0]   credit;
    logic [ENT_W-1:0]    mem [FIFO_DEPTH];

    assign fifo_empty[v]  = (wr_ptr == rd_ptr);
    assign fifo_full[v]   = ((wr_ptr - rd_ptr) == (PTR_W+1)'(FIFO_DEPTH));
    // Ready reflects fullness at the start of the cycle only; a same-cycle pop
    // does not open the FIFO for a same-cycle push.
    assign src_ready[v]   = reset & ~fifo_full[v];
    assign push[v]        = src_valid[v] & src_ready[v];
    assign pop[v]         = gnt_vld && (gnt_vc == VC_IDX_WIDTH'(v));
    assign ret[v]         = flow_ctrl_in[0] &&
                            (flow_ctrl_in[VC_IDX_WIDTH:1] == VC_IDX_WIDTH'(v));
    assign credit_full[v] = (credit == CRED_W'(CREDITS_PER_VC));
    assign eligible[v]    = !fifo_empty[v] && (credit != '0);
    assign ovf[v]         = ret[v] && !pop[v] && credit_full[v];
    assign head_ent[v]    = mem[rd_ptr[PTR_W-1:0]];

    // Payload storage; contents are don't-care until the pointers say valid.
    always_ff @(posedge clk) begin
      if (push[v])
        mem[wr_ptr[PTR_W-1:0]] <= {src_tail[v], src_head[v],
          src_data[(NUM_VCS-1-v)*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH]};
    end

    // FIFO pointers; reset drops every staged flit.
    always_ff @(posedge clk) begin
      if (!reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push[v]) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
        if (pop[v])  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
    end

    // Credit counter: grant spends, return refunds, both together cancel;
    // a return on a full counter is ignored (flagged through ovf).
    always_ff @(posedge clk) begin
      if (!reset)
        credit <= CRED_W'(CREDITS_PER_VC);
      else if (pop[v] && !ret[v])
        credit <= credit - CRED_W'(1);
      else if (ret[v] && !pop[v] && !credit_full[v])
        credit <= credit + CRED_W'(1);
    end

`ifdef NIC_INJ_PROTO_CHECK_EN
    logic pkt_open;
    logic ent_head;
    logic ent_tail;

    assign ent_tail     = head_ent[v][ENT_W-1];
    assign ent_head     = head_ent[v][ENT_W-2];
    assign proto_bad[v] = pop[v] && (ent_head ? pkt_open : !pkt_open);

    // Packet framing state, advanced only by flits actually granted.
    always_ff @(posedge clk) begin
      if (!reset)
        pkt_open <= 1'b0;
      else if (pop[v]) begin
        if (ent_tail)      pkt_open <= 1'b0;
        else if (ent_head) pkt_open <= 1'b1;
      end
    end
`else
    assign proto_bad[v] = 1'b0;
`endif
  end

  // Round-robin pick: first eligible VC at or after the pointer.
  always_comb begin
    logic [VC_IDX_WIDTH-1:0] idx_v;
    idx_v   = '0;
    gnt_vld = 1'b0;
    gnt_vc  = '0;
    for (int i = 0; i < NUM_VCS; i++) begin
      idx_v = VC_IDX_WIDTH'((int'(rr_ptr) + i) % NUM_VCS);
      if (!gnt_vld && eligible[idx_v]) begin
        gnt_vld = 1'b1;
        gnt_vc  = idx_v;
      end
    end
  end

  assign gnt_ent = head_ent[gnt_vc];

  // Pointer moves past the winner; held when nothing is granted.
  always_ff @(posedge clk) begin
    if (!reset)
      rr_ptr <= '0;
    else if (gnt_vld)
      rr_ptr <= (gnt_vc == VC_IDX_WIDTH'(NUM_VCS-1)) ? '0 : gnt_vc + VC_IDX_WIDTH'(1);
  end

  // ---- stage p1: granted flit registered onto the router channel ----
  always_ff @(posedge clk) begin
    if (!reset || !gnt_vld)
      chan_p1 <= '0;
    else
      chan_p1 <= {gnt_ent[FLIT_DATA_WIDTH-1:0], gnt_ent[ENT_W-1], gnt_ent[ENT_W-2],
                  gnt_vc[0], 1'b1};
  end

  // Sticky error: credit overflow, plus framing violations when checked.
  always_ff @(posedge clk) begin
    if (!reset)
      error_q <= 1'b0;
    else if ((|ovf) || (|proto_bad))
      error_q <= 1'b1;
  end

  assign channel_out = chan_p1;
  assign error       = error_q;
  assign idle        = (&fifo_empty) && (&credit_full) && !chan_p1[0];

endmodule

// File: tb/tb_nic_flit_injector.sv
// Testbench for nic_flit_injector: table of single-flit vectors plus
// multi-cycle sequences; every emitted flit is checked against a per-VC
// scoreboard filled when the bench drives an accepted flit.
module tb_nic_flit_injector;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   src_valid;
  logic [1:0]   src_ready;
  logic [1:0]   src_head;
  logic [1:0]   src_tail;
  logic [127:0] src_data;
  logic [67:0]  channel_out;
  logic [1:0]   flow_ctrl_in;
  logic         error;
  logic         idle;

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;
  int last_vc  = -1;
  logic [67:0] exp_q [2][$];
  int obs [$];

`ifdef NIC_INJ_PROTO_CHECK_EN
  localparam logic EXP_PROTO_ERR = 1'b1;
`else
  localparam logic EXP_PROTO_ERR = 1'b0;
`endif

  typedef struct {
    int          vc;
    logic        head;
    logic        tail;
    logic [63:0] data;
    logic [67:0] exp_out;
  } vec_t;

  vec_t tbl [4];

  nic_flit_injector dut (
    .clk          (clk),
    .reset        (reset),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_head     (src_head),
    .src_tail     (src_tail),
    .src_data     (src_data),
    .channel_out  (channel_out),
    .flow_ctrl_in (flow_ctrl_in),
    .error        (error),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Record accepted flits, advance one edge, then score any emitted flit.
  task automatic tick();
    logic        vb;
    logic [63:0] d;
    logic [67:0] e;
    for (int v = 0; v < 2; v++) begin
      vb = 1'(v);
      d  = vb ? src_data[63:0] : src_data[127:64];
      if (src_valid[vb] && src_ready[vb])
        exp_q[vb].push_back({d, src_tail[vb], src_head[vb], vb, 1'b1});
    end
    @(posedge clk);
    #1;
    if (channel_out[0] === 1'b1) begin
      vb = channel_out[1];
      n_out++;
      last_vc = int'(vb);
      checks++;
      if (exp_q[vb].size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got %h expected no flit on vc%0d", channel_out, vb);
      end else begin
        e = exp_q[vb].pop_front();
        if (channel_out !== e) begin
          failures++;
          $display("FAIL sb_flit: got %h expected %h", channel_out, e);
        end
      end
    end else begin
      last_vc = -1;
    end
  endtask

  task automatic send(input int v, input logic h, input logic t, input logic [63:0] d);
    logic vb;
    vb = 1'(v);
    src_valid[vb] = 1'b1;
    src_head[vb]  = h;
    src_tail[vb]  = t;
    if (vb) src_data[63:0] = d;
    else    src_data[127:64] = d;
    tick();
    src_valid[vb] = 1'b0;
  endtask

  task automatic ret(input int v);
    flow_ctrl_in = {1'(v), 1'b1};
    tick();
    flow_ctrl_in = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    exp_q[0].delete();
    exp_q[1].delete();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    int n0;
    tbl[0] = '{0, 1'b1, 1'b1, 64'h0000_0000_0000_A5A5, {64'h0000_0000_0000_A5A5, 4'b1101}};
    tbl[1] = '{1, 1'b1, 1'b1, 64'hDEAD_BEEF_0123_4567, {64'hDEAD_BEEF_0123_4567, 4'b1111}};
    tbl[2] = '{0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, {64'hFFFF_FFFF_FFFF_FFFF, 4'b1101}};
    tbl[3] = '{1, 1'b1, 1'b1, 64'h0000_0000_0000_0000, {64'h0000_0000_0000_0000, 4'b1111}};

    reset        = 1'b0;
    src_valid    = 2'b00;
    src_head     = 2'b00;
    src_tail     = 2'b00;
    src_data     = '0;
    flow_ctrl_in = 2'b00;

    // Reset state
    tick();
    tick();
    check("rst_ready", 68'(src_ready), 68'(2'b00));
    check("rst_chan", channel_out, 68'h0);
    reset = 1'b1;
    tick();
    check("rst_idle", 68'(idle), 68'(1'b1));
    check("rst_error", 68'(error), 68'(1'b0));
    check("rst_ready_rel", 68'(src_ready), 68'(2'b11));

    // Table: single flits, latency, credit return brings idle back
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].vc, tbl[i].head, tbl[i].tail, tbl[i].data);
      check("vec_nobypass", 68'(channel_out[0]), 68'(1'b0));
      tick();
      check("vec_out", channel_out, tbl[i].exp_out);
      check("vec_busy", 68'(idle), 68'(1'b0));
      ret(tbl[i].vc);
      check("vec_idle", 68'(idle), 68'(1'b1));
    end

    // 5-flit packet on VC1 with 4 credits: fifth held until one return
    n0 = n_out;
    send(1, 1'b1, 1'b0, 64'h1111_0000_0000_0001);
    send(1, 1'b0, 1'b0, 64'h1111_0000_0000_0002);
    send(1, 1'b0, 1'b0, 64'h1111_0000_0000_0003);
    send(1, 1'b0, 1'b0, 64'h1111_0000_0000_0004);
    send(1, 1'b0, 1'b1, 64'h1111_0000_0000_0005);
    repeat (4) tick();
    check("pkt_held", 68'(n_out - n0), 68'(4));
    ret(1);
    tick();
    check("pkt_fifth", 68'(n_out - n0), 68'(5));
    check("pkt_fifth_vc", 68'(last_vc), 68'(1));
    check("pkt_error", 68'(error), 68'(1'b0));
    repeat (4) ret(1);
    check("pkt_idle", 68'(idle), 68'(1'b1));

    // Both VCs loaded: strict alternation, no bubbles
    obs.delete();
    for (int i = 0; i < 4; i++) begin
      src_valid = 2'b11;
      src_head  = 2'b11;
      src_tail  = 2'b11;
      src_data  = {64'hA0A0_0000_0000_0000 + 64'(i), 64'hB0B0_0000_0000_0000 + 64'(i)};
      tick();
      obs.push_back(last_vc);
    end
    src_valid = 2'b00;
    repeat (6) begin
      tick();
      obs.push_back(last_vc);
    end
    check("alt_first_bubble", 68'(obs[0]), 68'(-1));
    for (int i = 0; i < 8; i++)
      check("alt_vc", 68'(obs[i+1]), 68'(i % 2));
    check("alt_after", 68'(obs[9]), 68'(-1));
    for (int i = 0; i < 4; i++) begin
      ret(0);
      ret(1);
    end
    check("alt_idle", 68'(idle), 68'(1'b1));

    // Grant and return on VC0 in the same cycle leave the credit unchanged
    send(0, 1'b1, 1'b1, 64'h5555_5555_5555_5555);
    flow_ctrl_in = 2'b01;
    tick();
    flow_ctrl_in = 2'b00;
    check("same_cycle_out", 68'(channel_out[0]), 68'(1'b1));
    check("same_cycle_err", 68'(error), 68'(1'b0));
    tick();
    check("same_cycle_idle", 68'(idle), 68'(1'b1));

    // Return on a full counter: sticky error
    ret(0);
    check("ovf_error", 68'(error), 68'(1'b1));
    repeat (3) tick();
    check("ovf_sticky", 68'(error), 68'(1'b1));
    do_reset();
    check("ovf_cleared", 68'(error), 68'(1'b0));

    // Two heads on VC0 without a tail
    n0 = n_out;
    send(0, 1'b1, 1'b0, 64'hC0C0_0000_0000_0001);
    send(0, 1'b1, 1'b0, 64'hC0C0_0000_0000_0002);
    repeat (2) tick();
    check("proto_both_sent", 68'(n_out - n0), 68'(2));
    check("proto_error", 68'(error), 68'(EXP_PROTO_ERR));
    do_reset();

    // Reset mid-packet with 3 flits queued behind exhausted credits
    for (int i = 0; i < 4; i++)
      send(0, 1'b1, 1'b1, 64'hD0D0_0000_0000_0000 + 64'(i));
    repeat (2) tick();
    n0 = n_out;
    send(0, 1'b1, 1'b0, 64'hE0E0_0000_0000_0001);
    send(0, 1'b0, 1'b0, 64'hE0E0_0000_0000_0002);
    send(0, 1'b0, 1'b0, 64'hE0E0_0000_0000_0003);
    tick();
    check("mid_queued", 68'(n_out - n0), 68'(0));
    reset = 1'b0;
    tick();
    check("mid_rst_chan", channel_out, 68'h0);
    check("mid_rst_ready", 68'(src_ready), 68'(2'b00));
    exp_q[0].delete();
    exp_q[1].delete();
    reset = 1'b1;
    tick();
    check("mid_idle", 68'(idle), 68'(1'b1));
    n0 = n_out;
    for (int i = 0; i < 4; i++)
      send(0, 1'b1, 1'b1, 64'hF0F0_0000_0000_0000 + 64'(i));
    repeat (3) tick();
    check("mid_credits4", 68'(n_out - n0), 68'(4));
    repeat (4) ret(0);
    check("mid_final_idle", 68'(idle), 68'(1'b1));

    check("sb_drained0", 68'(exp_q[0].size()), 68'(0));
    check("sb_drained1", 68'(exp_q[1].size()), 68'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
